// File: rtl/snake_dir_arbiter.sv
// Direction arbiter for a snake game core: queues up to two turns and commits one per game tick.
// Optional build macro SNAKE_DIR_REVERSE_FILTER_EN also rejects 180-degree reversals.
module snake_dir_arbiter (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Up,
    input  logic       Right,
    input  logic       Down,
    input  logic       Left,
    input  logic       Ack,
    input  logic       Run,
    input  logic       Tick,
    output logic [1:0] Dir,
    output logic       Step,
    output logic [1:0] Pending,
    output logic       Drop,
    output logic       Paused
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    state_t     state;
    logic [1:0] q_head;
    logic [1:0] q_tail;

    logic [3:0] btn;
    logic       any_btn;
    logic       multi_btn;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic       play_act;
    logic       pop;
    logic       push;
    logic       reject;
    logic       drop_nxt;

    // A turn is useless if it repeats the reference heading; the filter also blocks reversals.
    function automatic logic dir_rejected(input logic [1:0] c, input logic [1:0] base);
        logic r;
`ifdef SNAKE_DIR_REVERSE_FILTER_EN
        r = (c == base) || (c == (base ^ 2'b10));
`else
        r = (c == base);
`endif
        return r;
    endfunction

    always_comb begin
        btn       = {Up, Right, Down, Left};
        any_btn   = |btn;
        multi_btn = (btn & (btn - 4'd1)) != 4'd0;
        cand      = DIR_UP;
        if (Up)         cand = DIR_UP;
        else if (Right) cand = DIR_RIGHT;
        else if (Down)  cand = DIR_DOWN;
        else if (Left)  cand = DIR_LEFT;

        play_act = (state == PLAY) && Run;
        // Checking against the pre-pop tail keeps a same-cycle tick from changing the verdict.
        if (Pending == 2'd2)      ref_dir = q_tail;
        else if (Pending == 2'd1) ref_dir = q_head;
        else                      ref_dir = Dir;

        pop      = play_act && Tick && (Pending != 2'd0);
        reject   = dir_rejected(cand, ref_dir) || ((Pending == 2'd2) && !pop);
        push     = play_act && any_btn && !reject;
        drop_nxt = play_act && any_btn && (reject || multi_btn);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            Dir     <= DIR_RIGHT;
            Pending <= 2'd0;
            Step    <= 1'b0;
            Drop    <= 1'b0;
            Paused  <= 1'b0;
        end else begin
            Step <= play_act && Tick;
            Drop <= drop_nxt;
            if (!Run) begin
                state   <= IDLE;
                Dir     <= DIR_RIGHT;
                Pending <= 2'd0;
                Paused  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= PLAY;
                        Paused <= 1'b0;
                    end
                    PLAY: begin
                        if (Ack) begin
                            state  <= PAUSE;
                            Paused <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (Ack) begin
                            state  <= PLAY;
                            Paused <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        Paused <= 1'b0;
                    end
                endcase
                if (pop) Dir <= q_head;
                case ({pop, push})
                    2'b10:   Pending <= Pending - 2'd1;
                    2'b01:   Pending <= Pending + 2'd1;
                    default: Pending <= Pending;
                endcase
            end
        end
    end

    // Queue storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge CLK) begin
        if (push && pop) begin
            if (Pending == 2'd2) begin
                q_head <= q_tail;
                q_tail <= cand;
            end else begin
                q_head <= cand;
            end
        end else if (pop) begin
            q_head <= q_tail;
        end else if (push) begin
            if (Pending == 2'd0) q_head <= cand;
            else                 q_tail <= cand;
        end
    end

endmodule

// File: tb/tb_snake_dir_arbiter.sv
// Scoreboard bench for snake_dir_arbiter: each driven cycle queues its expected outputs for the monitor.
module tb_snake_dir_arbiter;

`ifdef SNAKE_DIR_REVERSE_FILTER_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Up = 1'b0, Right = 1'b0, Down = 1'b0, Left = 1'b0;
    logic       Ack = 1'b0, Run = 1'b0, Tick = 1'b0;
    logic [1:0] Dir;
    logic       Step;
    logic [1:0] Pending;
    logic       Drop;
    logic       Paused;

    typedef struct {
        int         idx;
        logic [1:0] dir;
        logic       step;
        logic [1:0] pend;
        logic       drop;
        logic       paused;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   row_n   = 0;

    snake_dir_arbiter dut (
        .CLK(CLK), .Reset(Reset), .Up(Up), .Right(Right), .Down(Down), .Left(Left),
        .Ack(Ack), .Run(Run), .Tick(Tick), .Dir(Dir), .Step(Step), .Pending(Pending),
        .Drop(Drop), .Paused(Paused)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs for one cycle plus the outputs expected right after the following rising edge.
    task automatic drive(input logic rst, input logic run, input logic ack, input logic tick,
                         input logic u, input logic r, input logic d, input logic l,
                         input logic [1:0] edir, input logic estep, input logic [1:0] epend,
                         input logic edrop, input logic epaused);
        exp_t e;
        Reset = rst; Run = run; Ack = ack; Tick = tick;
        Up = u; Right = r; Down = d; Left = l;
        e.idx = row_n; e.dir = edir; e.step = estep; e.pend = epend;
        e.drop = edrop; e.paused = epaused;
        sb.push_back(e);
        row_n++;
        @(negedge CLK);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("r%0d_dir", e.idx),    {6'd0, Dir},     {6'd0, e.dir});
                chk($sformatf("r%0d_step", e.idx),   {7'd0, Step},    {7'd0, e.step});
                chk($sformatf("r%0d_pend", e.idx),   {6'd0, Pending}, {6'd0, e.pend});
                chk($sformatf("r%0d_drop", e.idx),   {7'd0, Drop},    {7'd0, e.drop});
                chk($sformatf("r%0d_paused", e.idx), {7'd0, Paused},  {7'd0, e.paused});
            end
        end
    end

    initial begin
        @(negedge CLK);
        //     rst run ack tck U  R  D  L    dir    stp pend drop pau
        drive(1, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);   // IDLE -> PLAY
        drive(0, 1, 0, 0, 0, 1, 0, 0, 2'd1, 0, 2'd0, 1, 0);   // Right == Dir
        drive(0, 1, 0, 0, 1, 0, 0, 0, 2'd1, 0, 2'd1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd2, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 2'd1, 0, 2'd2, 1, 0);   // full
        drive(0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 1, 2'd1, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 2'd3, 1, 2'd0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 2'd3, 1, 2'd0, 0, 0);   // empty tick keeps Dir
        drive(0, 1, 0, 0, 1, 0, 0, 1, 2'd3, 0, 2'd1, 1, 0);   // Up beats Left
        drive(0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 2'd0, 0, REV ? 2'd0 : 2'd1, REV, 0);   // reversal of Up
        drive(0, 1, 0, 1, 0, 0, 0, 0, REV ? 2'd0 : 2'd2, 1, 2'd0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0, 0, REV ? 2'd0 : 2'd2, 0, 2'd1, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 1, 2'd0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 2'd1, 0, 2'd0, 1, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 0, 2'd1, 0, 2'd1, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 2'd1, 0, 2'd2, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 1, 0, 2'd0, 1, 2'd2, 0, 0);   // full + tick accepts push
        drive(0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 0, 1);   // pause
        drive(0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd2, 0, 1);
        drive(0, 1, 0, 0, 1, 0, 0, 0, 2'd0, 0, 2'd2, 0, 1);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 0, 0);   // resume
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);   // Run low flushes
        drive(0, 0, 0, 1, 1, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 0, 2'd1, 0, 2'd1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd2, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);   // Run low beats Ack
        drive(0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 2'd1, 0, 2'd1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd2, 0, 0);
        drive(0, 1, 0, 1, 1, 0, 0, 0, 2'd2, 1, 2'd2, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 2'd2, 0, 2'd2, 0, 0);

        @(negedge CLK);
        chk("sb_drain", sb.size(), 8'd0);

        // Asynchronous reset mid-game with two queued turns, checked before any clock edge.
        Reset = 1'b1;
        #1;
        chk("async_pend",   {6'd0, Pending}, 8'd0);
        chk("async_dir",    {6'd0, Dir},     8'd1);
        chk("async_paused", {7'd0, Paused},  8'd0);
        @(negedge CLK);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 2'd1, 0, 2'd0, 1, 0);   // PLAY reached on first edge
        drive(0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        @(negedge CLK);
        chk("sb_drain_end", sb.size(), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got %0d rows pending expected 0", sb.size());
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snake_dir_arbiter.md
SNAKE_DIR_ARBITER -- requirements
Module: snake_dir_arbiter

Interface
REQ-001 CLK  input  1  Single system clock; all state changes on its rising edge.
REQ-002 Reset  input  1  Asynchronous, active-high reset.
REQ-003 Up, Right, Down, Left  input  1 each  Debounced single-cycle button pulses.
REQ-004 Ack  input  1  Single-cycle pulse; toggles pause while playing.
REQ-005 Run  input  1  Level, high while the game core is in its play state.
REQ-006 Tick  input  1  Single-cycle game-step strobe.
REQ-007 Dir  output  2  Committed direction: 00 Up, 01 Right, 10 Down, 11 Left.
REQ-008 Step  output  1  Registered pulse; the core advances one cell using Dir.
REQ-009 Pending  output  2  Number of queued turns, 0..2.
REQ-010 Drop  output  1  Registered pulse; a button press was discarded this cycle.
REQ-011 Paused  output  1  High while in PAUSE.

Function
REQ-012 The block SHALL implement three states:
- IDLE: Run low.
- PLAY: Run high, not paused.
- PAUSE: Run high, paused.
REQ-013 State transitions SHALL be:
- IDLE->PLAY when Run is sampled high.
- PLAY->PAUSE on Ack.
- PAUSE->PLAY on Ack.
- Any state->IDLE when Run is sampled low (this takes priority over Ack).
REQ-014 On entry to IDLE, the block SHALL do the following on the same edge:
- Flush the queue.
- Set Dir to 01 (Right).
REQ-015 In IDLE and PAUSE:
- Button pulses SHALL be ignored, with no Drop.
- Tick SHALL produce no Step and SHALL NOT pop the queue.
REQ-016 In PLAY, simultaneous button pulses SHALL resolve by fixed priority Up>Right>Down>Left; the loser pulses SHALL assert Drop.
REQ-017 Each candidate SHALL be checked against a reference direction:
- The reference is the queue tail if Pending>0, otherwise Dir.
- A candidate equal to the reference SHALL be rejected.
- A candidate equal to the reference XOR 2'b10 (reversal) SHALL be rejected.
- Every rejection SHALL assert Drop.
REQ-018 Queue: 2-entry FIFO of 2-bit directions. A push when full SHALL be rejected with Drop, unless a pop occurs on the same cycle.
REQ-019 In PLAY on Tick:
- Step SHALL assert on the next edge (1-cycle latency).
- If Pending>0, the head SHALL be popped into Dir on that same edge.
- If Pending=0, Dir SHALL be unchanged.
REQ-020 Simultaneous Tick and accepted push:
- The pop SHALL take effect before the push, so a full queue accepts the push.
- The reference for the REQ-017 check SHALL be the pre-pop tail.
- Exception: if Pending=1 before the edge, the reference SHALL be that single entry.
REQ-021 Pending SHALL equal the exact FIFO occupancy and SHALL never exceed 2 or wrap.
REQ-022 Step and Drop SHALL each be high for exactly one cycle per event.

Reset
REQ-023 While Reset is high, the block SHALL hold:
- State IDLE.
- Dir=01.
- Queue empty, Pending=0.
- Step=0, Drop=0, Paused=0.
REQ-024 Reset asserted mid-operation SHALL discard all queued turns immediately and asynchronously.
REQ-025 After Reset deasserts, the first state transition SHALL occur on the next rising CLK edge.

Configuration
REQ-026 With SNAKE_DIR_REVERSE_FILTER_EN defined, REQ-017 reversal rejection SHALL apply.
REQ-027 Without SNAKE_DIR_REVERSE_FILTER_EN, reversals SHALL be queued like any other new direction; equal-direction rejection SHALL still apply.

Verification
REQ-028 Reset high, then Run=1, then Right pulse -> Drop=1, Pending=0, Dir=01.
REQ-029 PLAY, Dir=01: Up pulse, Left pulse, Down pulse, then Tick ->
- Up is queued.
- Left is queued (not a reversal of Up).
- Down is dropped (queue full).
- The Tick gives Dir=00, Step=1, Pending=1.
REQ-030 PLAY, Dir=01, macro defined: Left pulse -> Drop=1, Pending=0. Same stimulus with the macro undefined -> Pending=1, and the next Tick gives Dir=11.
REQ-031 Up and Left pulses on the same cycle -> Up queued, Drop=1.
REQ-032 Ack in PLAY, then Tick, then Ack -> Paused=1 with no Step; Paused=0 after the second Ack. Run low with Pending=2 -> Pending=0 and Dir=01 the next cycle.
REQ-033 Pending=2 with Tick and an accepted button pulse on the same cycle -> Pending stays 2 and Step=1.
